gift_dec: RTL and testbench
===========================

GIFT_DEC -- requirements
Module: gift_dec

Interface
REQ-001 SHALL have parameter ROUNDS, default 40: number of GIFT-128 rounds undone per block.
REQ-002 SHALL have port inClk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port inRst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port inKeyWr, input, 1: key-load strobe, sampled on the inClk edge.
REQ-005 SHALL have port inKeyData, input, 128: 128-bit master key, same bit order as the team's encryptor.
REQ-006 SHALL have port inDataWr, input, 1: ciphertext-load strobe.
REQ-007 SHALL have port inDataData, input, 128: ciphertext block.
REQ-008 SHALL have port outData, output, 128: registered plaintext, held until the next block completes.
REQ-009 SHALL have port outBusy, output, 1: high while a key precompute or a decryption is in progress.
REQ-010 SHALL have port outValid, output, 1: one-cycle pulse when outData is updated.
REQ-011 SHALL have port outKeyReady, output, 1: high once a key has been loaded and precomputed.

Function
REQ-012 SHALL implement the FSM states IDLE, PRECOMP and DEC.
REQ-013 IDLE + inKeyWr SHALL capture inKeyData, clear outKeyReady and go to PRECOMP.
REQ-014 PRECOMP SHALL apply the forward key schedule ROUNDS-1 times and step the 6-bit round-constant LFSR ROUNDS times from 0. This is one step per cycle, yielding the last-round key state and constant c_ROUNDS.
REQ-015 Forward constant step SHALL be {c[4:0], c5 XNOR c4}; inverse step SHALL be {c0 XNOR c5', c[5:1]}, where c5' is the recovered c5.
REQ-016 On PRECOMP completion the block SHALL set outKeyReady=1 and return to IDLE.
REQ-017 IDLE + inDataWr with outKeyReady=1 SHALL load inDataData into the state register and go to DEC.
REQ-018 Each DEC cycle SHALL apply, in order: AddRoundKey (current key state and constant, encoder bit positions incl. bit 127), InvPermBits, then InvSubCells (inverse GIFT S-box).
REQ-019 After each DEC round, the key state SHALL advance by the inverse key schedule and the constant by the inverse LFSR step.
REQ-020 After ROUNDS DEC cycles, outData SHALL be written with the last inverse-round output, outValid SHALL pulse for one cycle, and the FSM SHALL go to IDLE.
REQ-021 Latency: with inDataWr sampled at edge 0, outData and outValid SHALL appear after edge ROUNDS, with outBusy high from edge 0 through edge ROUNDS.
REQ-022 inKeyWr and inDataWr SHALL be ignored while outBusy=1, with no queuing.
REQ-023 inDataWr SHALL be ignored while outKeyReady=0.
REQ-024 If inKeyWr and inDataWr are asserted in the same IDLE cycle, the key SHALL win and the data SHALL be discarded.
REQ-025 outData SHALL be unchanged except on outValid.

Reset
REQ-026 While inRst=1, all of the following SHALL hold asynchronously:
  - FSM in IDLE;
  - outData=0, outBusy=0, outValid=0, outKeyReady=0;
  - round and constant counters at 0.
REQ-027 Reset mid-PRECOMP or mid-DEC SHALL abort the operation with no outValid.
REQ-028 After such a reset a key SHALL be reloaded before decryption is accepted.

Configuration
REQ-029 Macro GIFT_DEC_KEYCACHE_EN defined: the precomputed last-round key and constant SHALL be cached. Each DEC SHALL restart from the cache, and consecutive blocks under one key SHALL cost ROUNDS cycles each.
REQ-030 Macro GIFT_DEC_KEYCACHE_EN undefined: only the master key SHALL be stored, with these behaviour changes:
  - every accepted inDataWr SHALL run PRECOMP then DEC;
  - latency SHALL be 2*ROUNDS-1 edges;
  - outBusy SHALL be held throughout;
  - the key-load PRECOMP SHALL only set outKeyReady.

Structure
REQ-031 Package gift_pkg SHALL hold the following items, shared with the encryptor:
  - SBOX and INV_SBOX tables;
  - the PermBits index function and its inverse;
  - key-schedule rotate amounts;
  - the ROUNDS default;
  - the FSM state enum.
REQ-032 Combinational sub-module gift_inv_round (state, key, constant in; state out) SHALL implement REQ-018; the FSM, counters and key registers stay in gift_dec.

Verification
REQ-033 Key 128'h0 loaded, then the encryptor's ciphertext for plaintext 128'h0 -> outData=128'h0 and outValid pulse exactly ROUNDS edges after inDataWr.
REQ-034 Key 128'h000102...0F, 100 random plaintexts encrypted by the encryptor model, then decrypted back-to-back -> every outData equals its original plaintext; with the cache, per-block spacing = ROUNDS+1 cycles.
REQ-035 inDataWr before any key load -> no outBusy, no outValid, outData stays 0.
REQ-036 inKeyWr and inDataWr in the same IDLE cycle -> PRECOMP runs, no DEC starts, outValid never pulses.
REQ-037 inRst pulsed at DEC cycle 20 -> outBusy=0 and outKeyReady=0 immediately; no outValid; a subsequent inDataWr is ignored until a key is reloaded.
REQ-038 inKeyWr pulsed mid-DEC with a different key -> ignored; the current block completes with the original key's plaintext.

Source files
------------

// File: rtl/gift_pkg.sv
// GIFT-128 primitives shared by the block encryptor and decryptor.
package gift_pkg;

  localparam int unsigned GIFT_ROUNDS = 40;

  // Right-rotate amounts applied to key words k1 and k0 each forward schedule step
  localparam int unsigned KEY_ROT_K1 = 2;
  localparam int unsigned KEY_ROT_K0 = 12;

  localparam logic [3:0] SBOX [16] = '{
    4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
    4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'hd, 4'h0, 4'h8, 4'h6, 4'h2, 4'hc, 4'h4, 4'hb,
    4'he, 4'h7, 4'h1, 4'ha, 4'h3, 4'h9, 4'hf, 4'h5
  };

  typedef enum logic [1:0] {
    IDLE,
    PRECOMP,
    DEC
  } decState_t;

  // Destination of source bit i under PermBits
  function automatic int unsigned permIdx(input int unsigned i);
    return 4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4);
  endfunction

  // Source bit that PermBits moves into position j
  function automatic int unsigned invPermIdx(input int unsigned j);
    return 16 * ((j / 4) % 8) + 4 * ((3 * ((j / 32) + 4 - (j % 4))) % 4) + (j % 4);
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] x, input int unsigned n);
    return (x >> n) | (x << (16 - n));
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] x, input int unsigned n);
    return (x << n) | (x >> (16 - n));
  endfunction

  function automatic logic [127:0] keyFwd(input logic [127:0] k);
    return {rotr16(k[31:16], KEY_ROT_K1), rotr16(k[15:0], KEY_ROT_K0), k[127:32]};
  endfunction

  function automatic logic [127:0] keyInv(input logic [127:0] k);
    return {k[95:0], rotl16(k[127:112], KEY_ROT_K1), rotl16(k[111:96], KEY_ROT_K0)};
  endfunction

  function automatic logic [5:0] lfsrFwd(input logic [5:0] c);
    return {c[4:0], ~(c[5] ^ c[4])};
  endfunction

  // c5 of the previous constant is recovered from the new c0 and c5 (old c4)
  function automatic logic [5:0] lfsrInv(input logic [5:0] c);
    return {~(c[0] ^ c[5]), c[5:1]};
  endfunction

endpackage

// File: rtl/gift_inv_round.sv
// One combinational GIFT-128 inverse round: AddRoundKey, InvPermBits, InvSubCells.
module gift_inv_round
  import gift_pkg::*;
(
  input  logic [127:0] blockState,
  input  logic [127:0] roundKey,
  input  logic [5:0]   roundConst,
  output logic [127:0] nextState
);

  logic [127:0] ark;
  logic [127:0] perm;

  always_comb begin
    ark       = blockState;
    perm      = '0;
    nextState = '0;
    // U = k5||k4 feeds bit 4i+2, V = k1||k0 feeds bit 4i+1
    for (int unsigned i = 0; i < 32; i++) begin
      ark[4*i+2] = ark[4*i+2] ^ roundKey[64+i];
      ark[4*i+1] = ark[4*i+1] ^ roundKey[i];
    end
    ark[23]  = ark[23] ^ roundConst[5];
    ark[19]  = ark[19] ^ roundConst[4];
    ark[15]  = ark[15] ^ roundConst[3];
    ark[11]  = ark[11] ^ roundConst[2];
    ark[7]   = ark[7]  ^ roundConst[1];
    ark[3]   = ark[3]  ^ roundConst[0];
    ark[127] = ~ark[127];
    for (int unsigned i = 0; i < 128; i++) begin
      perm[i] = ark[permIdx(i)];
    end
    for (int unsigned n = 0; n < 32; n++) begin
      nextState[4*n +: 4] = INV_SBOX[perm[4*n +: 4]];
    end
  end

endmodule

// File: rtl/gift_dec.sv
// Iterative GIFT-128 decryptor: precomputes the last-round key, then undoes one round per cycle.
// Define GIFT_DEC_KEYCACHE_EN to cache the last-round key and constant across blocks.
module gift_dec
  import gift_pkg::*;
#(
  parameter int unsigned ROUNDS = GIFT_ROUNDS
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inKeyWr,
  input  logic [127:0] inKeyData,
  input  logic         inDataWr,
  input  logic [127:0] inDataData,
  output logic [127:0] outData,
  output logic         outBusy,
  output logic         outValid,
  output logic         outKeyReady
);

  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] DEC_LAST = CNT_W'(ROUNDS - 1);

  decState_t        state;
  logic [CNT_W-1:0] roundCnt;
  logic [127:0]     stateReg;
  logic [127:0]     keyReg;
  logic [5:0]       rcReg;
  logic [127:0]     roundOut;

`ifdef GIFT_DEC_KEYCACHE_EN
  logic [127:0] keyCache;
  logic [5:0]   rcCache;
`else
  logic [127:0] masterKey;
  logic         pendDec;
`endif

  gift_inv_round uInvRound (
    .blockState (stateReg),
    .roundKey   (keyReg),
    .roundConst (rcReg),
    .nextState  (roundOut)
  );

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state       <= IDLE;
      roundCnt    <= '0;
      stateReg    <= '0;
      keyReg      <= '0;
      rcReg       <= '0;
      outData     <= '0;
      outBusy     <= 1'b0;
      outValid    <= 1'b0;
      outKeyReady <= 1'b0;
`ifdef GIFT_DEC_KEYCACHE_EN
      keyCache    <= '0;
      rcCache     <= '0;
`else
      masterKey   <= '0;
      pendDec     <= 1'b0;
`endif
    end else begin
      outValid <= 1'b0;
      case (state)
        IDLE: begin
          // Key load takes priority; a simultaneous data strobe is dropped
          if (inKeyWr) begin
            keyReg      <= inKeyData;
            rcReg       <= lfsrFwd(6'h00);
            roundCnt    <= '0;
            outKeyReady <= 1'b0;
            outBusy     <= 1'b1;
            state       <= PRECOMP;
`ifndef GIFT_DEC_KEYCACHE_EN
            masterKey   <= inKeyData;
            pendDec     <= 1'b0;
`endif
          end else if (inDataWr && outKeyReady) begin
            stateReg <= inDataData;
            roundCnt <= '0;
            outBusy  <= 1'b1;
`ifdef GIFT_DEC_KEYCACHE_EN
            keyReg   <= keyCache;
            rcReg    <= rcCache;
            state    <= DEC;
`else
            keyReg   <= masterKey;
            rcReg    <= lfsrFwd(6'h00);
            pendDec  <= 1'b1;
            state    <= PRECOMP;
`endif
          end
        end

        PRECOMP: begin
          keyReg   <= keyFwd(keyReg);
          rcReg    <= lfsrFwd(rcReg);
          roundCnt <= roundCnt + CNT_W'(1);
          if (roundCnt == PRE_LAST) begin
            roundCnt <= '0;
`ifdef GIFT_DEC_KEYCACHE_EN
            keyCache    <= keyFwd(keyReg);
            rcCache     <= lfsrFwd(rcReg);
            outKeyReady <= 1'b1;
            outBusy     <= 1'b0;
            state       <= IDLE;
`else
            if (pendDec) begin
              state <= DEC;
            end else begin
              outKeyReady <= 1'b1;
              outBusy     <= 1'b0;
              state       <= IDLE;
            end
`endif
          end
        end

        DEC: begin
          stateReg <= roundOut;
          keyReg   <= keyInv(keyReg);
          rcReg    <= lfsrInv(rcReg);
          roundCnt <= roundCnt + CNT_W'(1);
          if (roundCnt == DEC_LAST) begin
            roundCnt <= '0;
            outData  <= roundOut;
            outValid <= 1'b1;
            outBusy  <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gift_dec.sv
// Scoreboard bench for gift_dec: an independent GIFT-128 encryptor produces ciphertexts.
module tb_gift_dec;

  localparam int R = 40;
`ifdef GIFT_DEC_KEYCACHE_EN
  localparam int LAT = R;
`else
  localparam int LAT = 2 * R - 1;
`endif

  localparam logic [3:0] GS [16] = '{
    4'h1, 4'ha, 4'h4, 4'hc, 4'h6, 4'hf, 4'h3, 4'h9,
    4'h2, 4'hd, 4'hb, 4'h7, 4'h5, 4'h0, 4'h8, 4'he
  };

  typedef struct {
    logic [127:0] pt;
    int           cyc;
  } sbEnt_t;

  logic         inClk = 1'b0;
  logic         inRst;
  logic         inKeyWr;
  logic [127:0] inKeyData;
  logic         inDataWr;
  logic [127:0] inDataData;
  logic [127:0] outData;
  logic         outBusy;
  logic         outValid;
  logic         outKeyReady;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [127:0] expOut = '0;
  sbEnt_t       sb[$];

  gift_dec #(.ROUNDS(R)) dut (
    .inClk       (inClk),
    .inRst       (inRst),
    .inKeyWr     (inKeyWr),
    .inKeyData   (inKeyData),
    .inDataWr    (inDataWr),
    .inDataData  (inDataData),
    .outData     (outData),
    .outBusy     (outBusy),
    .outValid    (outValid),
    .outKeyReady (outKeyReady)
  );

  always #5 inClk = ~inClk;
  always @(posedge inClk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference GIFT-128 encryption
  function automatic logic [127:0] encModel(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s, t, k;
    logic [5:0]   c;
    s = pt;
    k = key;
    c = '0;
    for (int r = 0; r < R; r++) begin
      for (int n = 0; n < 32; n++) t[4*n +: 4] = GS[s[4*n +: 4]];
      for (int i = 0; i < 128; i++)
        s[4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4)] = t[i];
      c = {c[4:0], ~(c[5] ^ c[4])};
      for (int i = 0; i < 32; i++) begin
        s[4*i+2] = s[4*i+2] ^ k[64+i];
        s[4*i+1] = s[4*i+1] ^ k[i];
      end
      s[23] = s[23] ^ c[5];
      s[19] = s[19] ^ c[4];
      s[15] = s[15] ^ c[3];
      s[11] = s[11] ^ c[2];
      s[7]  = s[7]  ^ c[1];
      s[3]  = s[3]  ^ c[0];
      s[127] = ~s[127];
      k = {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
    end
    return s;
  endfunction

  // Output monitor: pops the scoreboard on every outValid, otherwise outData must hold
  always begin
    sbEnt_t e;
    @(posedge inClk);
    #4;
    if (!inRst) begin
      if (outValid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 128'(outValid), 128'd0);
        end else begin
          e = sb.pop_front();
          chk("dec_data", outData, e.pt);
          chk("dec_latency", 128'(cyc), 128'(e.cyc));
          expOut = e.pt;
        end
      end else begin
        chk("out_hold", outData, expOut);
      end
    end
  end

  task automatic loadKey(input logic [127:0] k);
    @(negedge inClk);
    inKeyWr   = 1'b1;
    inKeyData = k;
    @(negedge inClk);
    inKeyWr = 1'b0;
    chk("precomp_busy", 128'(outBusy), 128'd1);
    chk("precomp_notready", 128'(outKeyReady), 128'd0);
    repeat (R - 2) @(negedge inClk);
    chk("precomp_pending", 128'(outKeyReady), 128'd0);
    @(negedge inClk);
    chk("key_ready", 128'(outKeyReady), 128'd1);
    chk("precomp_idle", 128'(outBusy), 128'd0);
  endtask

  // Drives a ciphertext at the current negedge and expects its plaintext LAT edges later
  task automatic sendBlock(input logic [127:0] pt, input logic [127:0] key);
    sbEnt_t e;
    inDataWr   = 1'b1;
    inDataData = encModel(pt, key);
    e.pt  = pt;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    @(negedge inClk);
    inDataWr = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((sb.size() != 0 || outBusy) && n < 4 * R) begin
      @(negedge inClk);
      n++;
    end
    chk("idle_busy", 128'(outBusy), 128'd0);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    @(negedge inClk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k1, k2, k3, pt;
    k1 = 128'h000102030405060708090a0b0c0d0e0f;
    k2 = 128'hfedcba98765432100123456789abcdef;
    k3 = 128'h5a5a5a5aa5a5a5a53c3c3c3cc3c3c3c3;
    inRst = 1'b1;
    inKeyWr = 1'b0;
    inDataWr = 1'b0;
    inKeyData = '0;
    inDataData = '0;

    repeat (3) @(negedge inClk);
    chk("rst_data", outData, 128'd0);
    chk("rst_busy", 128'(outBusy), 128'd0);
    chk("rst_valid", 128'(outValid), 128'd0);
    chk("rst_ready", 128'(outKeyReady), 128'd0);
    @(posedge inClk);
    #2 inRst = 1'b0;

    // Data before any key is ignored
    @(negedge inClk);
    inDataWr = 1'b1;
    inDataData = {$urandom, $urandom, $urandom, $urandom};
    @(negedge inClk);
    inDataWr = 1'b0;
    chk("nokey_busy", 128'(outBusy), 128'd0);
    repeat (LAT + 3) @(negedge inClk);
    chk("nokey_busy_late", 128'(outBusy), 128'd0);
    chk("nokey_data", outData, 128'd0);

    // All-zero key and plaintext
    loadKey('0);
    @(negedge inClk);
    sendBlock('0, '0);
    waitIdle();

    // Simultaneous key and data: key wins, no decryption
    @(negedge inClk);
    inKeyWr = 1'b1;
    inKeyData = k2;
    inDataWr = 1'b1;
    inDataData = {$urandom, $urandom, $urandom, $urandom};
    @(negedge inClk);
    inKeyWr = 1'b0;
    inDataWr = 1'b0;
    chk("both_busy", 128'(outBusy), 128'd1);
    chk("both_notready", 128'(outKeyReady), 128'd0);
    repeat (R - 1) @(negedge inClk);
    chk("both_ready", 128'(outKeyReady), 128'd1);
    chk("both_idle", 128'(outBusy), 128'd0);
    repeat (2 * R) @(negedge inClk);
    chk("both_still_idle", 128'(outBusy), 128'd0);
    pt = {$urandom, $urandom, $urandom, $urandom};
    sendBlock(pt, k2);
    waitIdle();

    // Key write during decryption is ignored
    @(negedge inClk);
    pt = {$urandom, $urandom, $urandom, $urandom};
    sendBlock(pt, k2);
    repeat (LAT - 10) @(negedge inClk);
    inKeyWr = 1'b1;
    inKeyData = k3;
    @(negedge inClk);
    inKeyWr = 1'b0;
    waitIdle();
    chk("midkey_ready", 128'(outKeyReady), 128'd1);
    pt = {$urandom, $urandom, $urandom, $urandom};
    sendBlock(pt, k2);
    waitIdle();

    // Back-to-back blocks under the incrementing-byte key
    loadKey(k1);
    @(negedge inClk);
    for (int b = 0; b < 100; b++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      sendBlock(pt, k1);
      repeat (LAT - 1) @(negedge inClk);
      chk("b2b_busy_hi", 128'(outBusy), 128'd1);
      @(negedge inClk);
      chk("b2b_busy_lo", 128'(outBusy), 128'd0);
    end
    waitIdle();

    // Reset at decryption round 20 aborts the block and drops the key
    pt = {$urandom, $urandom, $urandom, $urandom};
    sendBlock(pt, k1);
    repeat (LAT - R + 19) @(negedge inClk);
    @(posedge inClk);
    #2 inRst = 1'b1;
    sb.delete();
    expOut = '0;
    #1;
    chk("abort_busy", 128'(outBusy), 128'd0);
    chk("abort_ready", 128'(outKeyReady), 128'd0);
    chk("abort_valid", 128'(outValid), 128'd0);
    chk("abort_data", outData, 128'd0);
    repeat (3) @(posedge inClk);
    #2 inRst = 1'b0;
    @(negedge inClk);
    inDataWr = 1'b1;
    inDataData = encModel(pt, k1);
    @(negedge inClk);
    inDataWr = 1'b0;
    chk("postrst_busy", 128'(outBusy), 128'd0);
    repeat (LAT + 5) @(negedge inClk);
    chk("postrst_busy_late", 128'(outBusy), 128'd0);
    chk("postrst_ready", 128'(outKeyReady), 128'd0);

    // Reloading the key restores service
    loadKey(k1);
    @(negedge inClk);
    sendBlock(pt, k1);
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
